// File: rtl/cache_controller_if.sv
// cache_controller_if
//   Bundles the CPU, data-cache and main-memory signals of the cache
//   controller into one interface.
//   master : the cache controller. It receives CPU requests, drives cache
//            lookup/write controls and the memory request channel.
//   slave  : the surroundings (CPU, cache array, memory). They drive the
//            request, cache status/data and memory response.
interface cache_controller_if;
  // CPU side
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_is_word;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  // Data cache side
  logic        cache_hit;
  logic        cache_dirty;
  logic [31:0] cache_data;
  logic [31:0] cache_wb_addr;
  logic [31:0] cache_addr;
  logic [31:0] cache_wdata;
  logic        cache_we;
  logic        cache_is_word;
  logic        cache_set_valid;
  logic        cache_set_dirty;
  // Main memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  cache_hit, cache_dirty, cache_data, cache_wb_addr,
    output cache_addr, cache_wdata, cache_we, cache_is_word,
    output cache_set_valid, cache_set_dirty,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output cache_hit, cache_dirty, cache_data, cache_wb_addr,
    input  cache_addr, cache_wdata, cache_we, cache_is_word,
    input  cache_set_valid, cache_set_dirty,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller
//   Sequences one CPU load/store at a time through a direct-mapped,
//   write-back data cache: tag lookup, dirty-victim write-back, refill on
//   miss, store application and a one-cycle completion strobe. Keeps
//   saturating hit/miss/write-back statistics.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bus (master)         CPU request/response, cache control/status,
//                        memory request/response
//   hit_count            lookups that hit
//   miss_count           lookups that missed
//   wb_count             completed dirty-victim write-backs
module cache_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_controller_if.master   bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_WRITE   = 3'd4,
    S_RESPOND = 3'd5
  } state_t;

  state_t                state_r;
  state_t                next_state_s;

  // Latched request; the lookup address register doubles as the latched address.
  logic                  req_we_r;
  logic                  req_is_word_r;
  logic [31:0]           req_wdata_r;
  logic [31:0]           cache_addr_r;
  logic [31:0]           cpu_rdata_r;

  logic [CNT_WIDTH-1:0]  hit_cnt_r;
  logic [CNT_WIDTH-1:0]  miss_cnt_r;
  logic [CNT_WIDTH-1:0]  wb_cnt_r;

  logic                  accept_s;
  logic                  hit_inc_s;
  logic                  miss_inc_s;
  logic                  wb_inc_s;
  logic                  rdata_ld_s;
  logic [31:0]           rdata_nxt_s;

  // Saturating increment: all-ones is sticky.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus all cache/memory/CPU control outputs.
  always_comb begin
    next_state_s        = state_r;
    accept_s            = 1'b0;
    hit_inc_s           = 1'b0;
    miss_inc_s          = 1'b0;
    wb_inc_s            = 1'b0;
    rdata_ld_s          = 1'b0;
    rdata_nxt_s         = 32'd0;
    bus.cpu_ready       = 1'b0;
    bus.cache_we        = 1'b0;
    bus.cache_is_word   = 1'b0;
    bus.cache_wdata     = 32'd0;
    // The cache rewrites its flags every edge; by default keep a line that
    // is either a hit or dirty. A clean tag-mismatched line may drop valid,
    // which is harmless because only a miss can expose it.
    bus.cache_set_valid = bus.cache_hit | bus.cache_dirty;
    bus.cache_set_dirty = bus.cache_dirty;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = 32'd0;
    bus.mem_wdata       = 32'd0;

    case (state_r)
      S_IDLE: begin
        if (bus.cpu_req) begin
          accept_s     = 1'b1;
          next_state_s = S_LOOKUP;
        end else begin
          next_state_s = S_IDLE;
        end
      end

      S_LOOKUP: begin
        if (bus.cache_hit) begin
          hit_inc_s = 1'b1;
          if (req_we_r) begin
            next_state_s = S_WRITE;
          end else begin
            rdata_ld_s   = 1'b1;
            rdata_nxt_s  = bus.cache_data;
            next_state_s = S_RESPOND;
          end
        end else begin
          miss_inc_s = 1'b1;
          if (bus.cache_dirty) begin
            next_state_s = S_WB;
          end else begin
            next_state_s = S_FILL;
          end
        end
      end

      S_WB: begin
        // Request fields come from cache outputs that cannot change while
        // the line is not being written, so they stay stable until ack.
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.cache_wb_addr;
        bus.mem_wdata = bus.cache_data;
        if (bus.mem_ack) begin
          bus.cache_set_valid = 1'b0;
          bus.cache_set_dirty = 1'b0;
          wb_inc_s            = 1'b1;
          next_state_s        = S_FILL;
        end else begin
          next_state_s = S_WB;
        end
      end

      S_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {cache_addr_r[31:2], 2'b00};
        if (bus.mem_ack) begin
          bus.cache_we        = 1'b1;
          bus.cache_is_word   = 1'b1;
          bus.cache_wdata     = bus.mem_rdata;
          bus.cache_set_valid = 1'b1;
          bus.cache_set_dirty = 1'b0;
          if (req_we_r) begin
            next_state_s = S_WRITE;
          end else begin
            rdata_ld_s   = 1'b1;
            rdata_nxt_s  = bus.mem_rdata;
            next_state_s = S_RESPOND;
          end
        end else begin
          next_state_s = S_FILL;
        end
      end

      S_WRITE: begin
        bus.cache_we        = 1'b1;
        bus.cache_is_word   = req_is_word_r;
        bus.cache_wdata     = req_wdata_r;
        bus.cache_set_valid = 1'b1;
        bus.cache_set_dirty = 1'b1;
        next_state_s        = S_RESPOND;
      end

      S_RESPOND: begin
        bus.cpu_ready = 1'b1;
        next_state_s  = S_IDLE;
      end

      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Request capture; CPU inputs are ignored once the request is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_r      <= 1'b0;
      req_is_word_r <= 1'b0;
      req_wdata_r   <= 32'd0;
      cache_addr_r  <= 32'd0;
    end else if (accept_s) begin
      req_we_r      <= bus.cpu_we;
      req_is_word_r <= bus.cpu_is_word;
      req_wdata_r   <= bus.cpu_wdata;
      cache_addr_r  <= bus.cpu_addr;
    end
  end

  // Load result register; holds until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_r <= 32'd0;
    end else if (rdata_ld_s) begin
      cpu_rdata_r <= rdata_nxt_s;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= {CNT_WIDTH{1'b0}};
      miss_cnt_r <= {CNT_WIDTH{1'b0}};
      wb_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      if (hit_inc_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end
      if (miss_inc_s) begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
      if (wb_inc_s) begin
        wb_cnt_r <= sat_inc(wb_cnt_r);
      end
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.cache_addr = cache_addr_r;
  assign hit_count      = hit_cnt_r;
  assign miss_count     = miss_cnt_r;
  assign wb_count       = wb_cnt_r;

endmodule
